rf_writeback_ctrl: RTL and testbench

Write-back controller that is the writer side of the 32×32 register file's write port (`Rd_addr`, `Write_Rd_data`, `writeControl`). It accepts results from two producers, the single-cycle ALU path (A) and the multi-cycle load/multiply path (B), using valid/ready handshakes. A round-robin arbiter selects one result per cycle into a small FIFO, and the FIFO drains one register write per cycle unless stalled. Writes targeting x0 are filtered before the FIFO. A pending-destination mask is exported for hazard detection in decode.

---
 rtl/rf_writeback_ctrl.sv | 151 +++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl
//
// Writer side of the 32x32 register file write port. Two producers hand in
// results over valid/ready: path A (single-cycle ALU) and path B (multi-cycle
// load/multiply). A round-robin arbiter picks one result per cycle. Results
// for x0 are dropped. Everything else goes into a small circular FIFO, and the
// FIFO drains one register write per cycle unless wb_stall is high.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   a_valid/a_ready       ALU result handshake; a_rd, a_data payload
//   b_valid/b_ready       load/mul result handshake; b_rd, b_data payload
//   wb_stall              freezes draining (pipeline freeze / debug)
//   rf_we, rf_rd, rf_wdata  register file write port (writeControl, Rd_addr, Write_Rd_data)
//   pending_mask          bit r set while any queued entry targets register r
//   count                 FIFO occupancy
module rf_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [AW-1:0]            a_rd,
    input  logic [DW-1:0]            a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [AW-1:0]            b_rd,
    input  logic [DW-1:0]            b_data,
    input  logic                     wb_stall,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_rd,
    output logic [DW-1:0]            rf_wdata,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // FIFO storage and pointers
    logic [AW-1:0] mem_rd   [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    src_e          last_grant;
    src_e          last_grant_next;
    src_e          grant;

    logic          empty;
    logic          full;
    logic          pop;
    logic          space;
    logic          handshake;
    logic          push;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = !empty && !wb_stall;
    // A full FIFO can still take a result in a cycle that also pops.
    assign space = !full || pop;

    // Arbitration and next-grant state. The "not granted last time" rule only
    // applies when both sources compete; a lone source is always granted.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant           = SRC_A;
        last_grant_next = last_grant;
        if (a_valid && b_valid) begin
            grant = (last_grant == SRC_A) ? SRC_B : SRC_A;
        end else if (b_valid) begin
            grant = SRC_B;
        end
        if (handshake) begin
            last_grant_next = grant;
        end
    end

    // Readies are qualified by their own valid and forced low during reset,
    // because space is true whenever the (reset) FIFO is empty.
    assign a_ready   = rst && space && a_valid && (grant == SRC_A);
    assign b_ready   = rst && space && b_valid && (grant == SRC_B);
    assign handshake = a_ready || b_ready;

    assign in_rd   = (grant == SRC_A) ? a_rd   : b_rd;
    assign in_data = (grant == SRC_A) ? a_data : b_data;
    // x0 results complete their handshake but never occupy a slot.
    assign push    = handshake && (in_rd != '0);

    // Control state: pointers, occupancy and arbiter history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            last_grant <= SRC_A;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            last_grant <= last_grant_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read while
    // count marks it valid, so clearing it would cost flops for nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= in_data;
        end
    end

    // Head entry goes straight from storage to the register file port.
    assign rf_we    = pop;
    assign rf_rd    = empty ? '0 : mem_rd[rd_ptr];
    assign rf_wdata = empty ? '0 : mem_data[rd_ptr];

    // OR of one-hot destinations over the occupied slots, walking from head.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                pending_mask[mem_rd[rd_ptr + PW'(i)]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Testbench for rf_writeback_ctrl. A queue-based reference model predicts the
// handshakes, occupancy, pending mask and head entry every cycle; accepted
// non-x0 results are pushed to a scoreboard that a separate monitor drains
// whenever the DUT issues a register write.
module tb_rf_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic [AW-1:0] a_rd = '0;
    logic [DW-1:0] a_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [AW-1:0] b_rd = '0;
    logic [DW-1:0] b_data = '0;
    logic          wb_stall = 1'b0;
    logic          rf_we;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_wdata;
    logic [31:0]   pending_mask;
    logic [$clog2(DEPTH):0] count;

    int  n_cmp = 0;
    int  n_err = 0;

    wr_t mq[$];     // model FIFO contents, head first
    wr_t exp_q[$];  // scoreboard of writes still to appear
    logic m_last = 1'b0;  // 0 = A granted last, 1 = B

    logic [31:0] regfile [32];

    rf_writeback_ctrl #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .wb_stall     (wb_stall),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare against the
    // model, then advance the model past the next rising edge.
    task automatic cycle(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
                         input logic st);
        int          sz;
        logic        pe, sp, g, ear, ebr;
        logic [31:0] m;
        wr_t         w;
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        wb_stall = st;
        #1;
        sz = mq.size();
        pe = (sz > 0) && !st;
        sp = (sz < DEPTH) || pe;
        g  = (av && bv) ? !m_last : bv;
        ear = sp && av && !g;
        ebr = sp && bv && g;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        check("a_ready", 32'(a_ready), 32'(ear));
        check("b_ready", 32'(b_ready), 32'(ebr));
        check("rf_we", 32'(rf_we), 32'(pe));
        check("count", 32'(count), 32'(sz));
        check("pending_mask", pending_mask, m);
        check("rf_rd", 32'(rf_rd), (sz > 0) ? 32'(mq[0].rd) : 32'd0);
        check("rf_wdata", rf_wdata, (sz > 0) ? mq[0].data : 32'd0);
        if (pe) void'(mq.pop_front());
        if (ear || ebr) begin
            m_last = g;
            w.rd   = g ? brd : ard;
            w.data = g ? bd : ad;
            if (w.rd != 0) begin
                mq.push_back(w);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    // Asserts reset mid-cycle, checks the immediate clear, releases it on the
    // following falling edge.
    task automatic do_reset();
        rst = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_rd = 5'd3;
        b_rd = 5'd4;
        wb_stall = 1'b0;
        #1;
        check("rst a_ready", 32'(a_ready), 32'd0);
        check("rst b_ready", 32'(b_ready), 32'd0);
        check("rst rf_we", 32'(rf_we), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst pending_mask", pending_mask, 32'd0);
        check("rst rf_rd", 32'(rf_rd), 32'd0);
        check("rst rf_wdata", rf_wdata, 32'd0);
        mq.delete();
        exp_q.delete();
        m_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Monitor: every issued write must match the oldest outstanding result.
    always @(negedge clk) begin
        #2;
        if (rst && rf_we) begin
            check("write to x0", 32'(rf_rd == 0), 32'd0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected write: rd=%0d data=%h, none outstanding", rf_rd, rf_wdata);
            end else begin
                check("wr rd", 32'(rf_rd), 32'(exp_q[0].rd));
                check("wr data", rf_wdata, exp_q[0].data);
                void'(exp_q.pop_front());
            end
        end
    end

    // Register file capturing the write port on the rising edge.
    always @(posedge clk) begin
        if (rf_we) regfile[rf_rd] <= rf_wdata;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        do_reset();

        // Single ALU result into an empty FIFO.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        idle(3);

        // Both sources continuously valid: grants alternate.
        for (int i = 1; i <= 6; i++)
            cycle(1'b1, 5'(i), 32'h1000 + 32'(i), 1'b1, 5'(i), 32'h2000 + 32'(i), 1'b0);
        idle(3);

        // Stall with five results offered: four fit, the fifth waits for a pop.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 5'(10 + i), 32'hA000 + 32'(i), 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 5'd14, 32'hA004, 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 5'd14, 32'hA004, 1'b0, '0, '0, 1'b1);
        cycle(1'b1, 5'd14, 32'hA004, 1'b0, '0, '0, 1'b0);
        idle(6);

        // x0 results interleaved with rd=7.
        for (int i = 0; i < 6; i++)
            cycle(1'b1, (i % 2 == 0) ? 5'd0 : 5'd7, 32'hB000 + 32'(i),
                  1'b1, (i % 3 == 0) ? 5'd7 : 5'd0, 32'hC000 + 32'(i), 1'b0);
        idle(4);

        // Two writes to rd=9 queued under stall.
        cycle(1'b1, 5'd9, 32'h0000_1111, 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_2222, 1'b1);
        idle(4);
        check("x9 final value", regfile[9], 32'h0000_2222);

        // Reset mid-drain with three entries queued.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(20 + i), 32'hD000 + 32'(i), 1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #2;
        do_reset();
        idle(2);
        cycle(1'b0, '0, '0, 1'b1, 5'd25, 32'h2525_2525, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 12)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 12)), $urandom,
                  $urandom_range(0, 3) == 0);
        idle(DEPTH + 3);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
